// File: rtl/asmd_divider_if.sv
// Start/result handshake bundle for the restoring divider.
// The master issues operands with start; the slave returns ready, done and results.
interface asmd_divider_if #(
    parameter int word_length = 4
);
    logic                   start;
    logic [word_length-1:0] dividend;
    logic [word_length-1:0] divisor;
    logic                   ready;
    logic                   done;
    logic [word_length-1:0] quotient;
    logic [word_length-1:0] remainder;
    logic                   div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/asmd_divider.sv
// Sequential restoring shift-subtract divider: a two-state control FSM
// steering a shift/subtract datapath, one quotient bit per clock.
// Divide-by-zero and a zero dividend complete on the accept edge itself.
module asmd_divider #(
    parameter int word_length = 4
) (
    input  logic          clk,
    input  logic          reset,
    asmd_divider_if.slave bus
);
    localparam int cnt_w = $clog2(word_length + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t state;
    state_t state_next;

    logic [word_length-1:0] dreg;
    logic [word_length-1:0] qreg;
    logic [word_length-1:0] qreg_next;
    // The partial remainder is always below the divisor, so the top bit of the
    // (word_length+1)-bit remainder is constantly zero and is not stored.
    logic [word_length-1:0] rreg;
    logic [word_length-1:0] rreg_next;
    logic [cnt_w-1:0]       cnt;

    logic accept_div0;
    logic accept_zero;
    logic accept_run;
    logic step;
    logic finish;

    // One restoring iteration: shift in the next dividend bit, try the subtract,
    // keep the difference and shift in 1 when there is no borrow.
    function automatic logic [2*word_length-1:0] div_step(
        input logic [word_length-1:0] r,
        input logic [word_length-1:0] q,
        input logic [word_length-1:0] d
    );
        logic [word_length:0] shifted;
        logic [word_length:0] trial;
        shifted = {r, q[word_length-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[word_length]) begin
            return {trial[word_length-1:0], q[word_length-2:0], 1'b1};
        end
        return {shifted[word_length-1:0], q[word_length-2:0], 1'b0};
    endfunction

    assign bus.ready = (state == S_IDLE);

    // Next partial remainder and quotient shift register for the current iteration.
    always_comb begin
        {rreg_next, qreg_next} = div_step(rreg, qreg, dreg);
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_next  = state;
        accept_div0 = 1'b0;
        accept_zero = 1'b0;
        accept_run  = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        accept_div0 = 1'b1;
                    end else if (bus.dividend == '0) begin
                        accept_zero = 1'b1;
                    end else begin
                        accept_run = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == cnt_w'(1)) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers and registered results; results change only on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dreg            <= '0;
            qreg            <= '0;
            rreg            <= '0;
            cnt             <= '0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= accept_div0 | accept_zero | finish;
            if (accept_div0) begin
                bus.quotient    <= '1;
                bus.remainder   <= bus.dividend;
                bus.div_by_zero <= 1'b1;
            end else if (accept_zero) begin
                bus.quotient    <= '0;
                bus.remainder   <= '0;
                bus.div_by_zero <= 1'b0;
            end else if (accept_run) begin
                dreg            <= bus.divisor;
                qreg            <= bus.dividend;
                rreg            <= '0;
                cnt             <= cnt_w'(word_length);
                bus.div_by_zero <= 1'b0;
            end else if (step) begin
                rreg <= rreg_next;
                qreg <= qreg_next;
                cnt  <= cnt - cnt_w'(1);
                if (finish) begin
                    bus.quotient  <= qreg_next;
                    bus.remainder <= rreg_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_asmd_divider.sv
// Bench for asmd_divider: a 4-bit and an 8-bit instance run against an
// arithmetic model (integer / and %, edge countdown), directed cases with
// hand-computed literal expectations, then randomized per-cycle stimulus.
module tb_asmd_divider;
    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       st4 = 1'b0;
    logic [3:0] a4  = '0;
    logic [3:0] b4  = '0;
    logic       st8 = 1'b0;
    logic [7:0] a8  = '0;
    logic [7:0] b8  = '0;

    asmd_divider_if #(.word_length(4)) bus4 ();
    asmd_divider_if #(.word_length(8)) bus8 ();

    assign bus4.start    = st4;
    assign bus4.dividend = a4;
    assign bus4.divisor  = b4;
    assign bus8.start    = st8;
    assign bus8.dividend = a8;
    assign bus8.divisor  = b8;

    asmd_divider #(.word_length(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    asmd_divider #(.word_length(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    // model state, index 0 = 4-bit instance, 1 = 8-bit instance
    int m_left [2];
    int m_q    [2];
    int m_r    [2];
    int m_dbz  [2];
    int m_done [2];
    int m_pq   [2];
    int m_pr   [2];
    int m_a    [2];
    int m_b    [2];

    // literal expectations posted by the directed sequence (4-bit instance)
    string pin_name = "";
    int pin_q, pin_r, pin_dbz, pin_done, pin_ready;
    int pin_seq  = 0;
    int pin_seen = 0;

    function automatic int wl_of(input int s);
        return (s == 0) ? 4 : 8;
    endfunction
    function automatic int in_start(input int s);
        return (s == 0) ? int'(st4) : int'(st8);
    endfunction
    function automatic int in_a(input int s);
        return (s == 0) ? int'(a4) : int'(a8);
    endfunction
    function automatic int in_b(input int s);
        return (s == 0) ? int'(b4) : int'(b8);
    endfunction
    function automatic int dut_ready(input int s);
        return (s == 0) ? int'(bus4.ready) : int'(bus8.ready);
    endfunction
    function automatic int dut_done(input int s);
        return (s == 0) ? int'(bus4.done) : int'(bus8.done);
    endfunction
    function automatic int dut_q(input int s);
        return (s == 0) ? int'(bus4.quotient) : int'(bus8.quotient);
    endfunction
    function automatic int dut_r(input int s);
        return (s == 0) ? int'(bus4.remainder) : int'(bus8.remainder);
    endfunction
    function automatic int dut_dbz(input int s);
        return (s == 0) ? int'(bus4.div_by_zero) : int'(bus8.div_by_zero);
    endfunction

    // Behavioural model: a request seen while idle either completes at once
    // (zero divisor / zero dividend) or completes word_length edges later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0;
                m_q[i]    <= 0;
                m_r[i]    <= 0;
                m_dbz[i]  <= 0;
                m_done[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] <= 0;
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_q[i]    <= m_pq[i];
                        m_r[i]    <= m_pr[i];
                        m_done[i] <= 1;
                    end
                end else if (in_start(i) != 0) begin
                    m_a[i] <= in_a(i);
                    m_b[i] <= in_b(i);
                    if (in_b(i) == 0) begin
                        m_q[i]    <= (1 << wl_of(i)) - 1;
                        m_r[i]    <= in_a(i);
                        m_dbz[i]  <= 1;
                        m_done[i] <= 1;
                    end else if (in_a(i) == 0) begin
                        m_q[i]    <= 0;
                        m_r[i]    <= 0;
                        m_dbz[i]  <= 0;
                        m_done[i] <= 1;
                    end else begin
                        m_pq[i]   <= in_a(i) / in_b(i);
                        m_pr[i]   <= in_a(i) % in_b(i);
                        m_left[i] <= wl_of(i);
                        m_dbz[i]  <= 0;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge against the model, plus posted literals.
    initial begin
        repeat (3) @(posedge clk);
        forever begin
            @(negedge clk);
            cycle++;
            for (int i = 0; i < 2; i++) begin
                int er;
                er = (m_left[i] == 0) ? 1 : 0;
                vectors++;
                if (dut_ready(i) != er || dut_done(i) != m_done[i] || dut_q(i) != m_q[i] ||
                    dut_r(i) != m_r[i] || dut_dbz(i) != m_dbz[i]) begin
                    miscompares++;
                    $display("FAIL cycle%0d w%0d ready/done/q/r/dbz: got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                             cycle, wl_of(i), dut_ready(i), dut_done(i), dut_q(i), dut_r(i), dut_dbz(i),
                             er, m_done[i], m_q[i], m_r[i], m_dbz[i]);
                end
                if (dut_done(i) != 0 && dut_dbz(i) == 0) begin
                    vectors++;
                    if (m_a[i] != dut_q(i) * m_b[i] + dut_r(i) || dut_r(i) >= m_b[i]) begin
                        miscompares++;
                        $display("FAIL invariant w%0d: got q=%0d r=%0d for %0d/%0d, required q*d+r==%0d and r<%0d",
                                 wl_of(i), dut_q(i), dut_r(i), m_a[i], m_b[i], m_a[i], m_b[i]);
                    end
                end
            end
            #2;
            if (pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                vectors++;
                if (int'(bus4.quotient) != pin_q || int'(bus4.remainder) != pin_r ||
                    int'(bus4.div_by_zero) != pin_dbz || int'(bus4.done) != pin_done ||
                    int'(bus4.ready) != pin_ready) begin
                    miscompares++;
                    $display("FAIL %s q/r/dbz/done/ready: got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                             pin_name, bus4.quotient, bus4.remainder, bus4.div_by_zero, bus4.done, bus4.ready,
                             pin_q, pin_r, pin_dbz, pin_done, pin_ready);
                end
            end
        end
    end

    task automatic pin(input string name, input int q, input int r, input int dbz,
                       input int done, input int ready);
        pin_name  = name;
        pin_q     = q;
        pin_r     = r;
        pin_dbz   = dbz;
        pin_done  = done;
        pin_ready = ready;
        pin_seq++;
    endtask

    task automatic issue(input int a, input int b);
        @(posedge clk);
        #1;
        st4 = 1'b1;
        a4  = 4'(a);
        b4  = 4'(b);
        @(posedge clk);
        #1;
        st4 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus4.done) return;
        end
        $display("FAIL %s timeout: done got 0 within 20 cycles, required 1", name);
        $fatal(1);
    endtask

    // Directed sequence on the 4-bit instance, then random traffic on both.
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        issue(13, 3);
        @(negedge clk);
        pin("busy_13_3", 0, 0, 0, 0, 0);
        wait_done("div_13_3");
        pin("div_13_3", 4, 1, 0, 1, 1);

        issue(15, 1);
        wait_done("div_15_1");
        pin("div_15_1", 15, 0, 0, 1, 1);

        issue(3, 9);
        wait_done("div_3_9");
        pin("div_3_9", 0, 3, 0, 1, 1);

        issue(7, 0);
        wait_done("div_7_0");
        pin("div_7_0", 15, 7, 1, 1, 1);

        issue(8, 2);
        @(negedge clk);
        pin("dbz_cleared", 15, 7, 0, 0, 0);
        wait_done("div_8_2");
        pin("div_8_2", 4, 0, 0, 1, 1);

        issue(0, 5);
        wait_done("div_0_5");
        pin("div_0_5", 0, 0, 0, 1, 1);

        issue(14, 4);
        @(posedge clk);
        #1;
        st4 = 1'b1;
        a4  = 4'd9;
        b4  = 4'd3;
        @(posedge clk);
        #1;
        st4 = 1'b0;
        a4  = 4'd1;
        b4  = 4'd1;
        wait_done("div_14_4");
        pin("div_14_4", 3, 2, 0, 1, 1);
        st4 = 1'b1;
        a4  = 4'd11;
        b4  = 4'd2;
        @(posedge clk);
        #1;
        st4 = 1'b0;
        wait_done("b2b_11_2");
        pin("b2b_11_2", 5, 1, 0, 1, 1);

        issue(12, 5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        pin("reset_abort", 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            st4 = ($urandom_range(0, 2) == 0);
            a4  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            b4  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            st8 = ($urandom_range(0, 2) == 0);
            a8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            b8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1;
        st4 = 1'b0;
        st8 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
